// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: the fetch entry bundle and queue defaults.
// Occupancy classes are derived from the queue pointers, not stored.
package fetch_pkg;

  localparam int FETCHQ_DEPTH_DEFAULT = 4;
  localparam int FETCHQ_XLEN = 32;

  typedef struct packed {
    logic [FETCHQ_XLEN-1:0] pc;
    logic [FETCHQ_XLEN-1:0] inst;
    logic                   fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FQ_EMPTY,
    FQ_PARTIAL,
    FQ_FULL
  } fq_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer: DEPTH-entry FIFO with flush.
// Optional FETCHQ_BYPASS_EN: zero-latency pass-through when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH_DEFAULT,
  parameter int XLEN  = FETCHQ_XLEN
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     enq_valid_i,
  input  logic [XLEN-1:0]          enq_pc_i,
  input  logic [XLEN-1:0]          enq_inst_i,
  input  logic                     enq_fault_i,
  output logic                     enq_ready_o,
  output logic                     deq_valid_o,
  output logic [XLEN-1:0]          deq_pc_o,
  output logic [XLEN-1:0]          deq_inst_o,
  output logic                     deq_fault_o,
  input  logic                     deq_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t mem [DEPTH];
  fetch_entry_t head;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  fq_state_t     state;
  logic          byp;
  logic          enq_fire;
  logic          deq_fire;
  logic          wr_en;
  logic          rd_adv;

  // Occupancy class: equal index with differing MSB means full.
  always_comb begin
    state = FQ_PARTIAL;
    if (wr_ptr == rd_ptr)
      state = FQ_EMPTY;
    else if (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
      state = FQ_FULL;
  end

`ifdef FETCHQ_BYPASS_EN
  assign byp = (state == FQ_EMPTY) && enq_valid_i && !flush_i;
`else
  assign byp = 1'b0;
`endif

  assign enq_ready_o = (state != FQ_FULL);
  assign deq_valid_o = (state != FQ_EMPTY) || byp;
  assign enq_fire    = enq_valid_i && enq_ready_o;
  assign deq_fire    = deq_valid_o && deq_ready_i;
  // A bypassed entry consumed this cycle never touches storage.
  assign wr_en  = enq_fire && !flush_i && !(byp && deq_ready_i);
  assign rd_adv = deq_fire && !flush_i && !byp;
  assign head   = mem[rd_ptr[AW-1:0]];
  assign count_o = CW'(wr_ptr - rd_ptr);

  // Head presentation: bypass source, stored head, or zeros when idle.
  always_comb begin
    deq_pc_o    = '0;
    deq_inst_o  = '0;
    deq_fault_o = 1'b0;
    if (byp) begin
      deq_pc_o    = enq_pc_i;
      deq_inst_o  = enq_inst_i;
      deq_fault_o = enq_fault_i;
    end else if (state != FQ_EMPTY) begin
      deq_pc_o    = head.pc;
      deq_inst_o  = head.inst;
      deq_fault_o = head.fault;
    end
  end

  // Pointer update; flush wins over any same-cycle enq/deq.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; not reset, contents only matter behind the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= '{
        pc:    enq_pc_i,
        inst:  enq_inst_i,
        fault: enq_fault_i
      };
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: table vectors plus corner sequences.
// Bypass expectations follow FETCHQ_BYPASS_EN when defined.
module tb_fetch_queue;

`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_pc = '0;
  logic [31:0] enq_inst = '0;
  logic        enq_fault = 1'b0;
  logic        enq_ready;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;
  logic        deq_fault;
  logic        deq_ready = 1'b0;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .enq_valid_i (enq_valid),
    .enq_pc_i    (enq_pc),
    .enq_inst_i  (enq_inst),
    .enq_fault_i (enq_fault),
    .enq_ready_o (enq_ready),
    .deq_valid_o (deq_valid),
    .deq_pc_o    (deq_pc),
    .deq_inst_o  (deq_inst),
    .deq_fault_o (deq_fault),
    .deq_ready_i (deq_ready),
    .count_o     (count)
  );

  typedef struct {
    logic        fl;
    logic        ev;
    logic [31:0] pc;
    logic        ft;
    logic        dr;
    logic        x_er;
    logic        x_dv;
    logic [31:0] x_pc;
    logic        x_ft;
    logic [2:0]  x_cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic fl, input logic ev, input logic [31:0] pc,
    input logic ft, input logic dr, input logic x_er,
    input logic x_dv, input logic [31:0] x_pc,
    input logic x_ft, input logic [2:0] x_cnt);
    vec_t v;
    v.fl = fl; v.ev = ev; v.pc = pc; v.ft = ft; v.dr = dr;
    v.x_er = x_er; v.x_dv = x_dv; v.x_pc = x_pc;
    v.x_ft = x_ft; v.x_cnt = x_cnt;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // Drive one cycle's inputs after negedge, check settled outputs.
  task automatic step(input string tag, input vec_t v);
    logic [31:0] xi;
    @(negedge clk);
    flush = v.fl;
    enq_valid = v.ev;
    enq_pc = v.pc;
    enq_inst = v.pc ^ K;
    enq_fault = v.ft;
    deq_ready = v.dr;
    #1;
    xi = v.x_dv ? (v.x_pc ^ K) : 32'h0;
    chk({tag, ".enq_ready"}, 32'(enq_ready), 32'(v.x_er));
    chk({tag, ".deq_valid"}, 32'(deq_valid), 32'(v.x_dv));
    chk({tag, ".deq_pc"}, deq_pc, v.x_pc);
    chk({tag, ".deq_inst"}, deq_inst, xi);
    chk({tag, ".deq_fault"}, 32'(deq_fault), 32'(v.x_ft));
    chk({tag, ".count"}, 32'(count), 32'(v.x_cnt));
  endtask

  vec_t tbl [11];

  initial begin
    // fill then drain; row = inputs, outputs seen before the edge
    tbl[0]  = mk(0, 1, 32'h0,  0, 0, 1, BYP, 32'h0, 0, 0);
    tbl[1]  = mk(0, 1, 32'h4,  1, 0, 1, 1, 32'h0, 0, 1);
    tbl[2]  = mk(0, 1, 32'h8,  0, 0, 1, 1, 32'h0, 0, 2);
    tbl[3]  = mk(0, 1, 32'hC,  0, 0, 1, 1, 32'h0, 0, 3);
    tbl[4]  = mk(0, 1, 32'h10, 0, 0, 0, 1, 32'h0, 0, 4);
    tbl[5]  = mk(0, 0, 32'h0,  0, 0, 0, 1, 32'h0, 0, 4);
    tbl[6]  = mk(0, 1, 32'h20, 0, 1, 0, 1, 32'h0, 0, 4);
    tbl[7]  = mk(0, 0, 32'h0,  0, 1, 1, 1, 32'h4, 1, 3);
    tbl[8]  = mk(0, 0, 32'h0,  0, 1, 1, 1, 32'h8, 0, 2);
    tbl[9]  = mk(0, 0, 32'h0,  0, 1, 1, 1, 32'hC, 0, 1);
    tbl[10] = mk(0, 0, 32'h0,  0, 1, 1, 0, 32'h0, 0, 0);

    #1;
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.deq_valid", 32'(deq_valid), 32'd0);
    chk("reset.enq_ready", 32'(enq_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      step($sformatf("fill%0d", i), tbl[i]);

    // streaming across pointer wrap, occupancy held at one
    step("wrap0", mk(0, 1, 32'h200, 0, 0, 1, BYP,
                     BYP ? 32'h200 : 32'h0, 0, 0));
    for (int k = 1; k < 10; k++)
      step($sformatf("wrap%0d", k),
           mk(0, 1, 32'h200 + 32'(4 * k), 0, 1, 1, 1,
              32'h200 + 32'(4 * (k - 1)), 0, 1));
    step("wrap10", mk(0, 0, 32'h0, 0, 1, 1, 1, 32'h224, 0, 1));
    step("wrap11", mk(0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 0));

    // flush with three entries and a same-cycle enq/deq
    step("fl0", mk(0, 1, 32'h300, 0, 0, 1, BYP,
                   BYP ? 32'h300 : 32'h0, 0, 0));
    step("fl1", mk(0, 1, 32'h304, 0, 0, 1, 1, 32'h300, 0, 1));
    step("fl2", mk(0, 1, 32'h308, 0, 0, 1, 1, 32'h300, 0, 2));
    step("fl3", mk(1, 1, 32'h30C, 0, 1, 1, 1, 32'h300, 0, 3));
    step("fl4", mk(0, 1, 32'h100, 0, 0, 1, BYP,
                   BYP ? 32'h100 : 32'h0, 0, 0));
    step("fl5", mk(0, 0, 32'h0, 0, 1, 1, 1, 32'h100, 0, 1));
    step("fl6", mk(0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 0));

    // asynchronous reset mid-cycle with three entries held
    step("rs0", mk(0, 1, 32'h400, 0, 0, 1, BYP,
                   BYP ? 32'h400 : 32'h0, 0, 0));
    step("rs1", mk(0, 1, 32'h404, 0, 0, 1, 1, 32'h400, 0, 1));
    step("rs2", mk(0, 1, 32'h408, 0, 0, 1, 1, 32'h400, 0, 2));
    step("rs3", mk(0, 0, 32'h0, 0, 0, 1, 1, 32'h400, 0, 3));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.count", 32'(count), 32'd0);
    chk("midrst.deq_valid", 32'(deq_valid), 32'd0);
    chk("midrst.enq_ready", 32'(enq_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step("rs4", mk(0, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 0));

`ifdef FETCHQ_BYPASS_EN
    step("byp0", mk(0, 1, 32'h40, 1, 1, 1, 1, 32'h40, 1, 0));
    step("byp1", mk(0, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
